mem_port_arbiter: RTL

Shares one single-port, fixed-latency memory between the core's instruction-fetch stage (F) and data-memory stage (M). It grants at most one access per cycle and gives M priority, with a starvation guard that periodically grants F. It routes returning read data back to the requester that issued the read, and produces stall signals for the pipeline hazard logic. It sits between the riscv core ports (pcF/instrF, aluoutM/writedataM/readdataM) and the memory model.

---
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between fetch (F) and data (M) requesters.
// M has priority; a starvation counter forces an F grant after STARVE_MAX consecutive denials.
module mem_port_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [2:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        stallF,
  output logic        stallM
);

  localparam logic [3:0] StarveLimit = 4'(STARVE_MAX);

  logic [3:0]            starveCnt;
  logic                  forceF;
  logic [RD_LATENCY-1:0] tagValid;
  logic [RD_LATENCY-1:0] tagSrc;

  assign forceF = (starveCnt == StarveLimit);

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (d_req && !(if_req && forceF)) begin
        d_gnt = 1'b1;
      end else begin
        if_gnt = if_req;
      end
    end
  end

  always_comb begin
    m_req   = if_gnt | d_gnt;
    m_we    = 1'b0;
    m_size  = 3'b000;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    if (d_gnt) begin
      m_we    = d_we;
      m_size  = d_size;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (if_gnt) begin
      m_size  = 3'b010;
      m_addr  = if_addr;
    end
  end

  assign stallF = if_req & ~if_gnt;
  assign stallM = d_req & ~d_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      starveCnt <= 4'd0;
    end else if (if_gnt || !if_req) begin
      starveCnt <= 4'd0;
    end else if (starveCnt != StarveLimit) begin
      starveCnt <= starveCnt + 4'd1;
    end
  end

  // Tag pipeline mirrors the memory latency; src=1 marks a data-port read.
  always_ff @(posedge clk) begin
    if (reset) begin
      tagValid <= '0;
      tagSrc   <= '0;
    end else begin
      tagValid[0] <= m_req & ~m_we;
      tagSrc[0]   <= d_gnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tagValid[i] <= tagValid[i-1];
        tagSrc[i]   <= tagSrc[i-1];
      end
    end
  end

  // Gated by reset so a read issued just before reset never surfaces during it.
  assign if_rvalid = tagValid[RD_LATENCY-1] & ~tagSrc[RD_LATENCY-1] & ~reset;
  assign d_rvalid  = tagValid[RD_LATENCY-1] &  tagSrc[RD_LATENCY-1] & ~reset;
  assign if_rdata  = m_rdata;
  assign d_rdata   = m_rdata;

endmodule
